parity_frame_checker_mc: RTL and testbench

//  Multi-channel serial parity checker.

---
 rtl/parity_frame_checker_mc_if.sv | 36 +++
 rtl/parity_frame_checker_mc.sv | 106 ++++++++++
 tb/tb_parity_frame_checker_mc.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/parity_frame_checker_mc_if.sv
// rtl/parity_frame_checker_mc_if.sv - serial lane / status bundle for parity_frame_checker_mc
// err_count is present only when PARITY_ERR_CNT_EN is defined.
interface parity_frame_checker_mc_if #(
   parameter int NUM_CH    = 4,
   parameter int ERR_CNT_W = 8
);
   logic [NUM_CH-1:0] in_valid;
   logic [NUM_CH-1:0] x;
   logic [NUM_CH-1:0] clear;
   logic              odd_mode;
   logic [NUM_CH-1:0] parity;
   logic [NUM_CH-1:0] in_check;
   logic [NUM_CH-1:0] frame_done;
   logic [NUM_CH-1:0] parity_err;
`ifdef PARITY_ERR_CNT_EN
   logic [NUM_CH*ERR_CNT_W-1:0] err_count;

   modport master (
      output in_valid, x, clear, odd_mode,
      input  parity, in_check, frame_done, parity_err, err_count
   );
   modport slave (
      input  in_valid, x, clear, odd_mode,
      output parity, in_check, frame_done, parity_err, err_count
   );
`else
   modport master (
      output in_valid, x, clear, odd_mode,
      input  parity, in_check, frame_done, parity_err
   );
   modport slave (
      input  in_valid, x, clear, odd_mode,
      output parity, in_check, frame_done, parity_err
   );
`endif
endinterface

// File: rtl/parity_frame_checker_mc.sv
// rtl/parity_frame_checker_mc.sv - multi-channel bit-serial frame parity checker
// Optional saturating per-channel error counters under PARITY_ERR_CNT_EN.
module parity_frame_checker_mc #(
   parameter int NUM_CH    = 4,
   parameter int DATA_BITS = 8,
   parameter int ERR_CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   parity_frame_checker_mc_if.slave bus
);
   localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

   typedef enum logic {S_DATA, S_CHK} state_e;

   logic [NUM_CH-1:0] parity_w;
   logic [NUM_CH-1:0] in_check_w;
   logic [NUM_CH-1:0] done_w;
   logic [NUM_CH-1:0] err_w;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      state_e           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             acc_q, acc_d;
      logic             done_q, done_d;
      logic             err_q, err_d;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            err_q   <= err_d;
         end
      end

      // clear wins over in_valid and suppresses any pulse from this cycle
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         acc_d   = acc_q;
         done_d  = 1'b0;
         err_d   = 1'b0;
         if (bus.clear[c]) begin
            state_d = S_DATA;
            cnt_d   = '0;
            acc_d   = 1'b0;
         end else if (bus.in_valid[c]) begin
            case (state_q)
               S_DATA: begin
                  acc_d = acc_q ^ bus.x[c];
                  if (cnt_q == LAST_BIT) begin
                     cnt_d   = '0;
                     state_d = S_CHK;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               S_CHK: begin
                  done_d  = 1'b1;
                  err_d   = bus.x[c] != (acc_q ^ bus.odd_mode);
                  acc_d   = 1'b0;
                  cnt_d   = '0;
                  state_d = S_DATA;
               end
               default: state_d = S_DATA;
            endcase
         end
      end

      // the parity bit itself is never folded into the running value
      assign parity_w[c]   = (state_q == S_DATA) ? (acc_q ^ (bus.in_valid[c] & bus.x[c])) : acc_q;
      assign in_check_w[c] = (state_q == S_CHK);
      assign done_w[c]     = done_q;
      assign err_w[c]      = err_q;

`ifdef PARITY_ERR_CNT_EN
      logic [ERR_CNT_W-1:0] ecnt_q;

      // counts alongside err_d so the new value is visible with the pulse
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            ecnt_q <= '0;
         end else if (err_d && (ecnt_q != {ERR_CNT_W{1'b1}})) begin
            ecnt_q <= ecnt_q + 1'b1;
         end
      end

      assign bus.err_count[c*ERR_CNT_W +: ERR_CNT_W] = ecnt_q;
`endif
   end

   assign bus.parity     = parity_w;
   assign bus.in_check   = in_check_w;
   assign bus.frame_done = done_w;
   assign bus.parity_err = err_w;

endmodule

// File: tb/tb_parity_frame_checker_mc.sv
// tb/tb_parity_frame_checker_mc.sv - directed bench for parity_frame_checker_mc
// Counter checks run only when PARITY_ERR_CNT_EN is defined.
`define CHK(tag, obs, expv) \
   begin \
      n_vec++; \
      assert ((obs) === (expv)) else begin \
         n_err++; \
         $error("FAIL %s: observed %0h expected %0h", tag, (obs), (expv)); \
      end \
   end

module tb_parity_frame_checker_mc;
   localparam int NCH   = 4;
   localparam int DBITS = 8;
   localparam int ERR_W = 2;

   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;
   int   done_tot [NCH];
   int   err_tot  [NCH];

   parity_frame_checker_mc_if #(.NUM_CH(NCH), .ERR_CNT_W(ERR_W)) bus ();

   parity_frame_checker_mc #(
      .NUM_CH    (NCH),
      .DATA_BITS (DBITS),
      .ERR_CNT_W (ERR_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      for (int c = 0; c < NCH; c++) begin
         done_tot[c] = 0;
         err_tot[c]  = 0;
      end
   end

   always @(negedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         if (bus.frame_done[c]) done_tot[c]++;
         if (bus.parity_err[c]) err_tot[c]++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // sends d MSB first then parity bit pb on one channel, checking every step
   task automatic send_frame(input int ch, input logic [7:0] d, input logic pb,
                             input logic [7:0] pexp, input logic exp_err);
      for (int i = 0; i < 8; i++) begin
         bus.in_valid[ch] = 1'b1;
         bus.x[ch]        = d[7-i];
         #1;
         `CHK("parity_run", bus.parity[ch], pexp[7-i])
         tick();
      end
      `CHK("in_check_set", bus.in_check[ch], 1'b1)
      bus.x[ch] = pb;
      #1;
      `CHK("parity_in_chk", bus.parity[ch], pexp[0])
      tick();
      bus.in_valid[ch] = 1'b0;
      `CHK("frame_done", bus.frame_done[ch], 1'b1)
      `CHK("parity_err", bus.parity_err[ch], exp_err)
      `CHK("in_check_clr", bus.in_check[ch], 1'b0)
   endtask

   initial begin
      logic [8:0] good9;
      logic [8:0] bad9;
      int         ch1_cyc [9];
      int         d1, e1, d2, e2, d3, e3;

      good9   = 9'b1011_0001_0;
      bad9    = 9'b1011_0001_1;
      ch1_cyc = '{0, 1, 3, 6, 10, 15, 21, 22, 24};

      reset        = 1'b1;
      bus.in_valid = '0;
      bus.x        = '0;
      bus.clear    = '0;
      bus.odd_mode = 1'b0;
      #12;
      `CHK("rst_in_check", bus.in_check, 4'h0)
      `CHK("rst_done", bus.frame_done, 4'h0)
      `CHK("rst_err", bus.parity_err, 4'h0)
      `CHK("rst_parity", bus.parity, 4'h0)
      reset = 1'b0;
      tick();

      // three bits 1,0,0 leave acc=1, then asynchronous reset mid-frame
      bus.in_valid[0] = 1'b1;
      bus.x[0] = 1'b1; tick();
      bus.x[0] = 1'b0; tick();
      bus.x[0] = 1'b0; tick();
      bus.in_valid[0] = 1'b0;
      #1;
      `CHK("pre_rst_parity", bus.parity[0], 1'b1)
      #1;
      reset = 1'b1;
      #1;
      `CHK("midrst_in_check", bus.in_check[0], 1'b0)
      `CHK("midrst_done", bus.frame_done[0], 1'b0)
      `CHK("midrst_parity", bus.parity[0], 1'b0)
      #2;
      reset = 1'b0;
      tick();
      `CHK("postrst_done", bus.frame_done, 4'h0)

      // even mode good frame; also shows reset cleared the bit counter
      send_frame(0, 8'b1011_0001, 1'b0, 8'b1101_1110, 1'b0);
      tick();
      `CHK("done_one_cycle", bus.frame_done[0], 1'b0)

      // odd mode: parity bit 0 is wrong, 1 is right
      bus.odd_mode = 1'b1;
      send_frame(0, 8'b1011_0001, 1'b0, 8'b1101_1110, 1'b1);
      tick();
      `CHK("err_one_cycle", bus.parity_err[0], 1'b0)
      send_frame(0, 8'b1011_0001, 1'b1, 8'b1101_1110, 1'b0);
      bus.odd_mode = 1'b0;
      tick();

      // ch1 gapped good frame alongside ch2 back-to-back bad frames
      d1 = done_tot[1]; e1 = err_tot[1];
      d2 = done_tot[2]; e2 = err_tot[2];
      for (int cyc = 0; cyc < 28; cyc++) begin
         bus.in_valid[1] = 1'b0;
         for (int k = 0; k < 9; k++) begin
            if (ch1_cyc[k] == cyc) begin
               bus.in_valid[1] = 1'b1;
               bus.x[1]        = good9[8-k];
            end
         end
         bus.in_valid[2] = (cyc < 27);
         bus.x[2]        = bad9[8 - (cyc % 9)];
         tick();
         `CHK("ch2_done", bus.frame_done[2], (cyc < 27) && (cyc % 9 == 8))
         `CHK("ch2_err", bus.parity_err[2], (cyc < 27) && (cyc % 9 == 8))
      end
      bus.in_valid = '0;
      @(negedge clk);
      #1;
      `CHK("ch1_done_cnt", done_tot[1] - d1, 1)
      `CHK("ch1_err_cnt", err_tot[1] - e1, 0)
      `CHK("ch2_done_cnt", done_tot[2] - d2, 3)
      `CHK("ch2_err_cnt", err_tot[2] - e2, 3)
      tick();

      // clear on the 5th data bit of ch3, then a full good frame
      d3 = done_tot[3]; e3 = err_tot[3];
      bus.in_valid[3] = 1'b1;
      bus.x[3] = 1'b1; tick();
      bus.x[3] = 1'b0; tick();
      bus.x[3] = 1'b1; tick();
      bus.x[3] = 1'b1; tick();
      bus.x[3] = 1'b0;
      bus.clear[3] = 1'b1;
      tick();
      bus.clear[3]    = 1'b0;
      bus.in_valid[3] = 1'b0;
      `CHK("clr_no_done", bus.frame_done[3], 1'b0)
      #1;
      `CHK("clr_parity", bus.parity[3], 1'b0)
      tick();
      send_frame(3, 8'b1011_0001, 1'b0, 8'b1101_1110, 1'b0);
      tick();
      @(negedge clk);
      #1;
      `CHK("ch3_done_cnt", done_tot[3] - d3, 1)
      `CHK("ch3_err_cnt", err_tot[3] - e3, 0)

`ifdef PARITY_ERR_CNT_EN
      begin
         int exp_cnt [5];
         exp_cnt = '{1, 2, 3, 3, 3};
         tick();
         reset = 1'b1;
         #2;
         reset = 1'b0;
         tick();
         `CHK("cnt_rst", bus.err_count, 8'h00)
         for (int f = 0; f < 5; f++) begin
            send_frame(0, 8'b1011_0001, 1'b1, 8'b1101_1110, 1'b1);
            tick();
            `CHK("err_count_ch0", int'(bus.err_count[0 +: ERR_W]), exp_cnt[f])
            `CHK("err_count_other", bus.err_count[NCH*ERR_W-1:ERR_W], 6'h00)
         end
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
